// File: rtl/pc_branch_ctrl_if.sv
// ----------------------------------------------------------------------------
// pc_branch_ctrl_if
// Purpose : Bundles the branch-decode inputs and fetch-side outputs of the
//           PC / branch controller so one handle connects the pipeline to it.
// Signals :
//   stall      - hold request from the hazard unit
//   br_valid   - conditional branch present in decode this cycle
//   br_is_bne  - 1 = BNE, 0 = BEQ
//   bne_flag   - operand inequality from the not-equal comparator
//   br_pc      - byte address of the branch instruction
//   br_offset  - signed word offset from the immediate
//   pc         - registered fetch address
//   redirect   - one-cycle pulse after pc was loaded with a branch target
//   flush      - squash the wrong-path instruction in IF/ID
//   taken_cnt  - saturating count of taken branches
// Modports: master drives the decode side, slave is the controller itself.
// ----------------------------------------------------------------------------
interface pc_branch_ctrl_if;
    logic        stall;
    logic        br_valid;
    logic        br_is_bne;
    logic        bne_flag;
    logic [15:0] br_pc;
    logic [15:0] br_offset;
    logic [15:0] pc;
    logic        redirect;
    logic        flush;
    logic [7:0]  taken_cnt;

    modport master (
        output stall, br_valid, br_is_bne, bne_flag, br_pc, br_offset,
        input  pc, redirect, flush, taken_cnt
    );

    modport slave (
        input  stall, br_valid, br_is_bne, bne_flag, br_pc, br_offset,
        output pc, redirect, flush, taken_cnt
    );
endinterface

// File: rtl/pc_branch_ctrl.sv
// ----------------------------------------------------------------------------
// pc_branch_ctrl
// Purpose : Holds the fetch PC, resolves BEQ/BNE branches in decode and
//           redirects fetch with a single-cycle latency. The instruction
//           fetched right behind a taken branch is on the wrong path, so the
//           controller spends one SHADOW cycle in which branches are ignored
//           while that slot is squashed.
// Ports   :
//   clk     - single clock, rising edge
//   rst     - asynchronous active-high reset
//   bus     - pc_branch_ctrl_if.slave (decode inputs, pc/redirect/flush/count)
// ----------------------------------------------------------------------------
module pc_branch_ctrl (
    input  logic            clk,
    input  logic            rst,
    pc_branch_ctrl_if.slave bus
);

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } ctrlState_t;

    ctrlState_t  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  takenCnt_q, takenCnt_d;
    logic        redirect_q, redirect_d;
    logic        flush_q, flush_d;

    logic        branchTaken;
    logic [15:0] branchTarget;
    logic [15:0] pcPlusTwo;

    // Branch resolution: BNE is taken on inequality, BEQ on equality. The
    // word offset is doubled into a byte offset relative to the next
    // instruction; everything wraps modulo 2^16.
    always_comb begin
        branchTaken  = bus.br_valid & (bus.br_is_bne ? bus.bne_flag : ~bus.bne_flag);
        branchTarget = bus.br_pc + 16'd2 + {bus.br_offset[14:0], 1'b0};
        pcPlusTwo    = pc_q + 16'd2;
    end

    // Next-state logic. A stall freezes everything and drops the redirect
    // and flush pulses. Outside a stall, RUN either fetches sequentially or
    // jumps to the branch target and enters SHADOW; SHADOW always fetches
    // sequentially and returns to RUN, ignoring whatever sits in decode.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        takenCnt_d = takenCnt_q;
        redirect_d = 1'b0;
        flush_d    = 1'b0;

        if (!bus.stall) begin
            unique case (state_q)
                RUN: begin
                    if (branchTaken) begin
                        pc_d       = branchTarget;
                        state_d    = SHADOW;
                        redirect_d = 1'b1;
                        flush_d    = 1'b1;
                        if (takenCnt_q != 8'hFF) begin
                            takenCnt_d = takenCnt_q + 8'd1;
                        end
                    end else begin
                        pc_d = pcPlusTwo;
                    end
                end
                SHADOW: begin
                    pc_d    = pcPlusTwo;
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State register. Reset is asynchronous so a reset arriving mid-SHADOW
    // clears the outputs immediately and abandons the shadow slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= 16'h0000;
            takenCnt_q <= 8'h00;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            takenCnt_q <= takenCnt_d;
            redirect_q <= redirect_d;
            flush_q    <= flush_d;
        end
    end

    // All outputs come straight from registers.
    assign bus.pc        = pc_q;
    assign bus.redirect  = redirect_q;
    assign bus.flush     = flush_q;
    assign bus.taken_cnt = takenCnt_q;

endmodule
